// File: rtl/cmp_arbiter.sv
// Two-requester compare engine: arbitrate, latch one job, compare a > b, hold the result until taken.
// Define CMP_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_agtb,
  input  logic             rsp_ready,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lat_a, lat_b;
  logic             lat_mode, lat_id;
  logic             grant1;
  logic             in_idle;
  logic             accept;
  logic             cmp_gt;

`ifdef CMP_ARBITER_RR_EN
  logic last_grant;

  // Under contention the requester that did not win last time goes next.
  always_comb grant1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk) begin
    if (reset)       last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`else
  always_comb grant1 = req1_valid & ~req0_valid;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Readys never look at rsp_ready; a valid dropped before its transfer leaves no trace.
  assign in_idle    = (state == IDLE) & ~reset;
  assign req0_ready = in_idle & req0_valid & ~grant1;
  assign req1_ready = in_idle & req1_valid & grant1;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign cmp_gt = lat_mode ? ($signed(lat_a) > $signed(lat_b)) : (lat_a > lat_b);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CMP;
      CMP:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_a    <= '0;
      lat_b    <= '0;
      lat_mode <= 1'b0;
      lat_id   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_agtb <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        lat_a    <= grant1 ? req1_a : req0_a;
        lat_b    <= grant1 ? req1_b : req0_b;
        lat_mode <= grant1 ? req1_mode : req0_mode;
        lat_id   <= grant1;
      end
      if (state == CMP) begin
        rsp_agtb <= cmp_gt;
        rsp_id   <= lat_id;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign state_dbg = state;

endmodule
